// File: rtl/fsm_upload_flit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_upload_flit_if
//  Description : Request handshake and request-fifo write signals shared
//                between an upload requester/fifo side and the upload
//                flit controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fsm_upload_flit_if;
    // Request side: held stable by the requester until req_ack
    logic       req_valid;
    logic       req_inv;
    logic [3:0] req_flit_max;
    logic [3:0] req_inv_ids;
    logic       req_ack;
    logic       upload_done;
    logic       busy;
    // Request fifo side
    logic       fifo_full;
    logic       fifo_wr;

    // Requester / fifo environment
    modport master (
        output req_valid,
        output req_inv,
        output req_flit_max,
        output req_inv_ids,
        output fifo_full,
        input  req_ack,
        input  upload_done,
        input  busy,
        input  fifo_wr
    );

    // Upload flit controller
    modport slave (
        input  req_valid,
        input  req_inv,
        input  req_flit_max,
        input  req_inv_ids,
        input  fifo_full,
        output req_ack,
        output upload_done,
        output busy,
        output fifo_wr
    );
endinterface
`default_nettype wire

// File: rtl/fsm_upload_flit.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_upload_flit
//  Description : Control FSM that uploads a message into the request fifo,
//                either once to a single destination (sc/wb/flush) or once
//                per set bit of the invalidation vector (invreq multicast).
//                All outputs are decoded combinationally from the state and
//                the current inputs; the datapath counters and registers
//                live outside this block.
//  Revision    : 1.0 - initial release
// ============================================================================
module fsm_upload_flit (
    input  wire logic         clk,
    input  wire logic         rst,               // asynchronous, active low
    fsm_upload_flit_if.slave  bus,
    // Datapath status
    input  wire logic         cnt_eq_max,
    input  wire logic         cnt_invs_eq_3,
    input  wire logic         cnt_eq_0,
    input  wire logic [3:0]   inv_ids_reg_out,
    input  wire logic [1:0]   sel_cnt_invs_out,
    // Datapath controls
    output logic              clr_max,
    output logic              clr_inv_ids,
    output logic              clr_sel_cnt,
    output logic              clr_sel_cnt_inv,
    output logic              inc_sel_cnt,
    output logic              inc_sel_cnt_inv,
    output logic              en_flit_max_in,
    output logic              en_for_reg,
    output logic              en_inv_ids,
    output logic              dest_sel,
    output logic [3:0]        flit_max_in
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        INV_SCAN = 2'd2,
        INV_SEND = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // The flit-index-zero flag is not needed to sequence the upload; it is
    // kept on the port list so the datapath wiring stays uniform.
    logic unused_status;
    assign unused_status = cnt_eq_0;

    // Node currently addressed by the multicast scan has a pending invalidation
    logic inv_hit;
    assign inv_hit = inv_ids_reg_out[sel_cnt_invs_out];

    // Next-state and output decode; everything is forced low while in reset
    always_comb begin
        state_nxt       = state;
        bus.req_ack     = 1'b0;
        bus.upload_done = 1'b0;
        bus.busy        = 1'b0;
        bus.fifo_wr     = 1'b0;
        clr_max         = 1'b0;
        clr_inv_ids     = 1'b0;
        clr_sel_cnt     = 1'b0;
        clr_sel_cnt_inv = 1'b0;
        inc_sel_cnt     = 1'b0;
        inc_sel_cnt_inv = 1'b0;
        en_flit_max_in  = 1'b0;
        en_for_reg      = 1'b0;
        en_inv_ids      = 1'b0;
        dest_sel        = 1'b0;
        flit_max_in     = 4'd0;

        if (rst) begin
            flit_max_in = bus.req_flit_max;
            bus.busy    = (state != IDLE);

            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ack     = 1'b1;
                        en_for_reg      = 1'b1;
                        en_flit_max_in  = 1'b1;
                        clr_sel_cnt     = 1'b1;
                        clr_sel_cnt_inv = 1'b1;
                        en_inv_ids      = bus.req_inv;
                        state_nxt       = bus.req_inv ? INV_SCAN : SEND;
                    end
                end

                SEND: begin
                    dest_sel = 1'b1;
                    // A full fifo freezes everything except dest_sel
                    if (!bus.fifo_full) begin
                        bus.fifo_wr = 1'b1;
                        if (cnt_eq_max) begin
                            clr_sel_cnt     = 1'b1;
                            clr_max         = 1'b1;
                            bus.upload_done = 1'b1;
                            state_nxt       = IDLE;
                        end else begin
                            inc_sel_cnt = 1'b1;
                        end
                    end
                end

                INV_SCAN: begin
                    // One cycle per examined node index, independent of fifo_full
                    if (inv_hit) begin
                        state_nxt = INV_SEND;
                    end else if (cnt_invs_eq_3) begin
                        clr_inv_ids     = 1'b1;
                        clr_sel_cnt_inv = 1'b1;
                        clr_max         = 1'b1;
                        bus.upload_done = 1'b1;
                        state_nxt       = IDLE;
                    end else begin
                        inc_sel_cnt_inv = 1'b1;
                    end
                end

                INV_SEND: begin
                    if (!bus.fifo_full) begin
                        bus.fifo_wr = 1'b1;
                        if (cnt_eq_max) begin
                            // Copy for this node complete; rewind flit index
                            clr_sel_cnt = 1'b1;
                            if (cnt_invs_eq_3) begin
                                clr_inv_ids     = 1'b1;
                                clr_sel_cnt_inv = 1'b1;
                                clr_max         = 1'b1;
                                bus.upload_done = 1'b1;
                                state_nxt       = IDLE;
                            end else begin
                                inc_sel_cnt_inv = 1'b1;
                                state_nxt       = INV_SCAN;
                            end
                        end else begin
                            inc_sel_cnt = 1'b1;
                        end
                    end
                end

                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register; reset abandons any message in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fsm_upload_flit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsm_upload_flit
//  Description : Self-checking bench for fsm_upload_flit. A small datapath
//                model answers the status inputs; expected behaviour comes
//                from a per-message work list of scan and write steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_upload_flit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fsm_upload_flit_if bus();

    logic       cnt_eq_max, cnt_invs_eq_3, cnt_eq_0;
    logic [3:0] inv_ids_reg_out;
    logic [1:0] sel_cnt_invs_out;
    logic       clr_max, clr_inv_ids, clr_sel_cnt, clr_sel_cnt_inv;
    logic       inc_sel_cnt, inc_sel_cnt_inv, en_flit_max_in, en_for_reg;
    logic       en_inv_ids, dest_sel;
    logic [3:0] flit_max_in;

    fsm_upload_flit dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .cnt_eq_max      (cnt_eq_max),
        .cnt_invs_eq_3   (cnt_invs_eq_3),
        .cnt_eq_0        (cnt_eq_0),
        .inv_ids_reg_out (inv_ids_reg_out),
        .sel_cnt_invs_out(sel_cnt_invs_out),
        .clr_max         (clr_max),
        .clr_inv_ids     (clr_inv_ids),
        .clr_sel_cnt     (clr_sel_cnt),
        .clr_sel_cnt_inv (clr_sel_cnt_inv),
        .inc_sel_cnt     (inc_sel_cnt),
        .inc_sel_cnt_inv (inc_sel_cnt_inv),
        .en_flit_max_in  (en_flit_max_in),
        .en_for_reg      (en_for_reg),
        .en_inv_ids      (en_inv_ids),
        .dest_sel        (dest_sel),
        .flit_max_in     (flit_max_in)
    );

    // Datapath model: flit counter, node counter, flit-max and inv-vector registers
    logic [3:0] dp_flit_max, dp_sel_cnt, dp_inv_ids;
    logic [1:0] dp_sel_inv;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_flit_max <= 4'd0;
            dp_sel_cnt  <= 4'd0;
            dp_inv_ids  <= 4'd0;
            dp_sel_inv  <= 2'd0;
        end else begin
            if (en_flit_max_in)     dp_flit_max <= flit_max_in;
            else if (clr_max)       dp_flit_max <= 4'd0;
            if (clr_sel_cnt)        dp_sel_cnt  <= 4'd0;
            else if (inc_sel_cnt)   dp_sel_cnt  <= dp_sel_cnt + 4'd1;
            if (clr_sel_cnt_inv)    dp_sel_inv  <= 2'd0;
            else if (inc_sel_cnt_inv) dp_sel_inv <= dp_sel_inv + 2'd1;
            if (en_inv_ids)         dp_inv_ids  <= bus.req_inv_ids;
            else if (clr_inv_ids)   dp_inv_ids  <= 4'd0;
        end
    end
    assign cnt_eq_max       = (dp_sel_cnt == dp_flit_max);
    assign cnt_invs_eq_3    = (dp_sel_inv == 2'd3);
    assign cnt_eq_0         = (dp_sel_cnt == 4'd0);
    assign inv_ids_reg_out  = dp_inv_ids;
    assign sel_cnt_invs_out = dp_sel_inv;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One work step of a message: a scan of one node index, or one flit write
    typedef struct {
        bit scan;
        int node;
        int flit;
    } step_t;

    function automatic logic [13:0] all_outs();
        return {bus.req_ack, bus.fifo_wr, bus.upload_done, bus.busy, clr_max,
                clr_inv_ids, clr_sel_cnt, clr_sel_cnt_inv, inc_sel_cnt,
                inc_sel_cnt_inv, en_flit_max_in, en_for_reg, en_inv_ids, dest_sel};
    endfunction

    // Idle cycle with no request: every control output stays low
    task automatic idle_cycle();
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.fifo_full = 1'($urandom_range(0, 1));
        #1;
        chk("idle_outputs", 32'(all_outs()), 32'd0);
    endtask

    // Issue one request and follow it to completion against the work list.
    // fifo_full is high on cycle k (k=0 is the accept cycle) when mask[k] is
    // set or with pct percent probability.
    task automatic run_msg(input bit inv, input int fmax, input logic [3:0] ids,
                           input int pct, input logic [31:0] mask);
        step_t q[$];
        step_t s;
        int    k;
        @(posedge clk); #1;
        bus.req_valid    = 1'b1;
        bus.req_inv      = inv;
        bus.req_flit_max = fmax[3:0];
        bus.req_inv_ids  = ids;
        bus.fifo_full    = 1'($urandom_range(0, 1));
        #1;
        chk("accept_ack",     32'(bus.req_ack), 32'd1);
        chk("accept_busy",    32'(bus.busy), 32'd0);
        chk("accept_wr",      32'(bus.fifo_wr), 32'd0);
        chk("accept_en_inv",  32'(en_inv_ids), 32'(inv));
        chk("accept_ctl",     32'({en_for_reg, en_flit_max_in, clr_sel_cnt, clr_sel_cnt_inv}), 32'hf);
        chk("accept_flitmax", 32'(flit_max_in), 32'(fmax));

        if (!inv) begin
            for (int f = 0; f <= fmax; f++) q.push_back('{scan: 1'b0, node: 0, flit: f});
        end else begin
            for (int n = 0; n < 4; n++) begin
                q.push_back('{scan: 1'b1, node: n, flit: 0});
                if (ids[n])
                    for (int f = 0; f <= fmax; f++) q.push_back('{scan: 1'b0, node: n, flit: f});
            end
        end

        k = 0;
        while (q.size() > 0 && k < 300) begin
            k++;
            @(posedge clk); #1;
            // Requests presented while busy must be ignored
            bus.req_valid    = 1'($urandom_range(0, 1));
            bus.req_inv      = 1'($urandom_range(0, 1));
            bus.req_flit_max = 4'($urandom_range(0, 15));
            bus.req_inv_ids  = 4'($urandom_range(0, 15));
            bus.fifo_full    = ((k < 32) ? mask[k] : 1'b0) | (int'($urandom_range(0, 99)) < pct);
            #1;
            s = q[0];
            chk("busy",          32'(bus.busy), 32'd1);
            chk("ack_when_busy", 32'(bus.req_ack), 32'd0);
            chk("inc_without_wr", 32'(inc_sel_cnt & ~bus.fifo_wr), 32'd0);
            if (s.scan) begin
                chk("scan_wr",   32'(bus.fifo_wr), 32'd0);
                chk("scan_dest", 32'(dest_sel), 32'd0);
                chk("scan_node", 32'(dp_sel_inv), 32'(s.node));
                chk("scan_done", 32'(bus.upload_done), 32'(q.size() == 1));
                void'(q.pop_front());
            end else if (bus.fifo_full) begin
                chk("stall_wr",   32'(bus.fifo_wr), 32'd0);
                chk("stall_inc",  32'(inc_sel_cnt), 32'd0);
                chk("stall_done", 32'(bus.upload_done), 32'd0);
                chk("stall_dest", 32'(dest_sel), 32'(!inv));
            end else begin
                chk("write_wr",   32'(bus.fifo_wr), 32'd1);
                chk("write_dest", 32'(dest_sel), 32'(!inv));
                chk("write_flit", 32'(dp_sel_cnt), 32'(s.flit));
                if (inv) chk("write_node", 32'(dp_sel_inv), 32'(s.node));
                chk("write_done", 32'(bus.upload_done), 32'(q.size() == 1));
                void'(q.pop_front());
            end
        end
        if (q.size() > 0) begin
            chk("msg_timeout_steps_left", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        bus.req_valid    = 1'b1;
        bus.req_inv      = 1'b0;
        bus.req_flit_max = 4'd3;
        bus.req_inv_ids  = 4'hf;
        bus.fifo_full    = 1'b0;
        #3;
        // In reset everything is low, even with a request pending
        chk("reset_outputs", 32'(all_outs()), 32'd0);
        chk("reset_flitmax", 32'(flit_max_in), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;

        idle_cycle();
        // Single-dest, 3 flits, no back-pressure
        run_msg(1'b0, 2, 4'h0, 0, 32'h0);
        // Multicast to nodes 1 and 3
        run_msg(1'b1, 2, 4'b1010, 0, 32'h0);
        // Empty multicast: four scans, done on the last
        run_msg(1'b1, 2, 4'b0000, 0, 32'h0);
        // Single-dest with fifo_full on T+2..T+4
        run_msg(1'b0, 2, 4'h0, 0, 32'h0000_001c);
        // Back-to-back single-flit requests
        run_msg(1'b0, 0, 4'h0, 0, 32'h0);
        run_msg(1'b0, 0, 4'h0, 0, 32'h0);
        // Multicast including node 3, single flit
        run_msg(1'b1, 0, 4'b1001, 0, 32'h0);
        idle_cycle();

        // Reset during the second flit of an INV_SEND copy
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_inv = 1'b1;
        bus.req_flit_max = 4'd3; bus.req_inv_ids = 4'b0001; bus.fifo_full = 1'b0;
        #1; chk("rst_seq_ack", 32'(bus.req_ack), 32'd1);
        @(posedge clk); #1; bus.req_valid = 1'b0; #1;
        chk("rst_seq_scan_busy", 32'(bus.busy), 32'd1);
        @(posedge clk); #2;
        chk("rst_seq_flit0_wr", 32'(bus.fifo_wr), 32'd1);
        @(posedge clk); #2;
        chk("rst_seq_flit1_wr", 32'(bus.fifo_wr), 32'd1);
        rst = 1'b0;
        bus.req_valid = 1'b1;
        #1;
        chk("rst_async_busy", 32'(bus.busy), 32'd0);
        chk("rst_async_wr",   32'(bus.fifo_wr), 32'd0);
        chk("rst_async_all",  32'(all_outs()), 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_all", 32'(all_outs()), 32'd0);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        run_msg(1'b0, 1, 4'h0, 0, 32'h0);

        // Randomized messages with random back-pressure
        repeat (25) begin
            run_msg(1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
                    4'($urandom_range(0, 15)), int'($urandom_range(0, 50)), 32'h0);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fsm_upload_flit.md
FSM_UPLOAD_FLIT -- requirements
Module: fsm_upload_flit

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  upload request pending; requester holds it and its fields until req_ack.
REQ-005 req_inv  in  1  1 = invreq multicast (dest from inv vector); 0 = single-dest sc/wb/flush (dest from head flit).
REQ-006 req_flit_max  in  4  index of last flit of message (flit count minus 1).
REQ-007 req_inv_ids  in  4  invalidation target vector; bit i = node i.
REQ-008 fifo_full  in  1  request fifo cannot accept a flit this cycle.
REQ-009 cnt_eq_max, cnt_invs_eq_3, cnt_eq_0  in  1 each  datapath status.
REQ-010 inv_ids_reg_out  in  4; sel_cnt_invs_out  in  2  datapath status.
REQ-011 clr_max, clr_inv_ids, clr_sel_cnt, clr_sel_cnt_inv, inc_sel_cnt, inc_sel_cnt_inv, en_flit_max_in, en_for_reg, en_inv_ids, dest_sel  out  1 each  datapath controls.
REQ-012 flit_max_in  out  4  equals req_flit_max.
REQ-013 fifo_wr  out  1  write datapath flit_out into request fifo this cycle.
REQ-014 req_ack  out  1  one-cycle request-accept pulse.
REQ-015 upload_done  out  1  one-cycle pulse on the cycle the message's final flit (or empty-multicast scan) completes.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 States: IDLE, SEND (single-dest), INV_SCAN, INV_SEND; 2-bit encoded state register; all outputs combinational from state and inputs.
REQ-018 IDLE, req_valid=1: req_ack=1, en_for_reg=1, en_flit_max_in=1, clr_sel_cnt=1, clr_sel_cnt_inv=1; en_inv_ids=req_inv; next SEND if req_inv=0 else INV_SCAN.
REQ-019 IDLE, req_valid=0: all control outputs 0, stay IDLE.
REQ-020 SEND: dest_sel=1; fifo_wr=!fifo_full; fifo_full=1 -> no outputs change, hold state.
REQ-021 SEND write with cnt_eq_max=0: inc_sel_cnt=1, stay.
REQ-022 SEND write with cnt_eq_max=1: clr_sel_cnt=1, clr_max=1, upload_done=1, next IDLE.
REQ-023 INV_SCAN (dest_sel=0, fifo_wr=0): if inv_ids_reg_out[sel_cnt_invs_out]=1 -> next INV_SEND; else if cnt_invs_eq_3=1 -> clr_inv_ids, clr_sel_cnt_inv, clr_max, upload_done=1, next IDLE; else inc_sel_cnt_inv=1, stay.
REQ-024 INV_SEND: dest_sel=0; fifo_wr=!fifo_full; stall on fifo_full as REQ-020; non-last write: inc_sel_cnt=1.
REQ-025 INV_SEND last write (cnt_eq_max=1): clr_sel_cnt=1; if cnt_invs_eq_3=1 -> clr_inv_ids, clr_sel_cnt_inv, clr_max, upload_done=1, next IDLE; else inc_sel_cnt_inv=1, next INV_SCAN.
REQ-026 Single-dest message of N=req_flit_max+1 flits: first fifo_wr cycle after acceptance, N write cycles absent fifo_full.
REQ-027 Multicast: one full copy per set bit, ascending node order 0..3; one INV_SCAN cycle per examined index.
REQ-028 Empty inv vector: no fifo_wr, upload_done 4 cycles after req_ack cycle.
REQ-029 req_flit_max=0: single-flit message, write and done same cycle.
REQ-030 req_valid ignored outside IDLE; back-to-back request accepted the cycle after upload_done.
REQ-031 fifo_wr never asserted while fifo_full=1; inc_sel_cnt only with fifo_wr.

Reset
REQ-032 rst=0 forces IDLE immediately, asynchronously; all outputs 0 while rst=0 (req_ack included, regardless of req_valid).
REQ-033 Reset mid-message abandons it; no further fifo_wr; datapath cleared by its own reset.

Verification
REQ-034 Single-dest, req_flit_max=2, fifo never full -> req_ack at T, fifo_wr T+1..T+3, upload_done at T+3, dest_sel=1 throughout.
REQ-035 Multicast req_inv_ids=4'b1010, req_flit_max=2 -> flits written for node 1 then node 3, 6 fifo_wr total, upload_done on 6th write.
REQ-036 Multicast req_inv_ids=4'b0000 -> zero fifo_wr, upload_done at T+4.
REQ-037 Single-dest, fifo_full high T+2..T+4 -> writes at T+1, T+5, T+6; inc_sel_cnt never during stall.
REQ-038 rst asserted low during INV_SEND second flit -> busy=0 and fifo_wr=0 same cycle; new request after release completes normally.
REQ-039 Two back-to-back single-flit requests -> req_ack at T and T+2, upload_done at T+1 and T+3.
